// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by both the TX and RX sides.
//   - 3-bit FSM state encodings and the state enum built from them
//   - parity-type constants (PAR_EVEN / PAR_ODD)
//   - default payload width for a frame
// No ports (package).
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } tx_state_t;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// ---------------------------------------------------------------------------
// uart_tx_parity_calc
// Combinational parity generator for one frame payload.
// Ports:
//   data    [DATA_WIDTH-1:0] in  payload to protect
//   par_typ                  in  PAR_EVEN (0) or PAR_ODD (1)
//   parity                   out parity bit to place on the line
// ---------------------------------------------------------------------------
module uart_tx_parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  parity
);

  // Even parity is the plain XOR reduction; odd parity is its inverse.
  assign parity = (par_typ == PAR_ODD) ? ~(^data) : (^data);

endmodule

// File: rtl/uart_tx_core.sv
// ---------------------------------------------------------------------------
// uart_tx_core
// UART transmitter: one serial bit per clk edge, frame = start, DATA_WIDTH
// data bits LSB first, optional parity, stop. Line idles high.
// Ports:
//   clk                          in  bit clock
//   rst                          in  synchronous reset, active low
//   p_data   [DATA_WIDTH-1:0]    in  parallel payload
//   data_valid                   in  payload valid (only taken in IDLE)
//   par_en                       in  insert parity bit after data
//   par_typ                      in  0 = even, 1 = odd parity
//   tx_out                       out serial line (registered)
//   busy                         out frame in progress (registered)
// ---------------------------------------------------------------------------
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  tx_out,
  output logic                  busy
);

  // Counter must be at least one bit wide even for a 1-bit payload.
  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  tx_state_t             state;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic                  par_en_reg;
  logic                  par_typ_reg;
  logic                  parity_bit;

  // Parity is taken from the captured copy so input changes mid-frame
  // cannot affect the bit that goes out.
  uart_tx_parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity (
    .data    (data_reg),
    .par_typ (par_typ_reg),
    .parity  (parity_bit)
  );

  // Outputs are registered together with the state: each transition loads
  // the line value belonging to the state being entered, so tx_out always
  // shows the bit of the current state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      tx_out      <= 1'b1;
      busy        <= 1'b0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      data_reg    <= '0;
      par_en_reg  <= 1'b0;
      par_typ_reg <= PAR_EVEN;
    end else begin
      case (state)
        IDLE: begin
          tx_out <= 1'b1;
          busy   <= 1'b0;
          if (data_valid) begin
            data_reg    <= p_data;
            shift_reg   <= p_data;
            par_en_reg  <= par_en;
            par_typ_reg <= par_typ;
            bit_cnt     <= '0;
            state       <= START;
            tx_out      <= 1'b0;
            busy        <= 1'b1;
          end
        end

        START: begin
          state     <= DATA;
          tx_out    <= shift_reg[0];
          shift_reg <= shift_reg >> 1;
          bit_cnt   <= '0;
        end

        // bit_cnt counts the data bit currently on the line; once the last
        // one has had its cycle, move on to parity or stop.
        DATA: begin
          if (bit_cnt == LAST_BIT) begin
            bit_cnt <= '0;
            if (par_en_reg) begin
              state  <= PARITY;
              tx_out <= parity_bit;
            end else begin
              state  <= STOP;
              tx_out <= 1'b1;
            end
          end else begin
            tx_out    <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= bit_cnt + CNT_W'(1);
          end
        end

        PARITY: begin
          state  <= STOP;
          tx_out <= 1'b1;
        end

        STOP: begin
          state  <= IDLE;
          tx_out <= 1'b1;
          busy   <= 1'b0;
        end

        default: begin
          state  <= IDLE;
          tx_out <= 1'b1;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_core
// Self-checking bench for uart_tx_core (DATA_WIDTH = 8). A reference model
// keeps the line bits still to be sent as a queue: a frame is loaded when the
// queue is empty and data_valid is seen, one bit is consumed per clock, and
// reset empties it.
// ---------------------------------------------------------------------------
module tb_uart_tx_core;

  logic       clk;
  logic       rst;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_en;
  logic       par_typ;
  logic       tx_out;
  logic       busy;

  int unsigned checks;
  int unsigned errors;

  bit          model_q[$];
  logic        exp_tx;
  logic        exp_busy;
  logic [31:0] line_hist;

  uart_tx_core #(
    .DATA_WIDTH(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .tx_out     (tx_out),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Line bits of one frame, in transmission order.
  task automatic loadFrame(input logic [7:0] d, input logic pe, input logic pt);
    int ones;
    ones = $countones(d);
    model_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) model_q.push_back(d[i]);
    if (pe) model_q.push_back(1'(ones % 2) ^ pt);
    model_q.push_back(1'b1);
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then
  // compare both outputs shortly after the edge.
  task automatic applyStimulus(input logic r, input logic v, input logic [7:0] d,
                               input logic pe, input logic pt);
    rst        = r;
    data_valid = v;
    p_data     = d;
    par_en     = pe;
    par_typ    = pt;
    @(posedge clk);
    if (!r) model_q.delete();
    else if (model_q.size() == 0) begin
      if (v) loadFrame(d, pe, pt);
    end else void'(model_q.pop_front());
    exp_busy = (model_q.size() != 0);
    exp_tx   = exp_busy ? model_q[0] : 1'b1;
    #1;
    line_hist = {line_hist[30:0], tx_out};
    checkOutput("tx_out", {31'd0, tx_out}, {31'd0, exp_tx});
    checkOutput("busy", {31'd0, busy}, {31'd0, exp_busy});
  endtask

  task automatic idleSteps(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    line_hist  = '0;
    rst        = 1'b0;
    data_valid = 1'b0;
    p_data     = 8'h00;
    par_en     = 1'b0;
    par_typ    = 1'b0;

    $display("[TB] reset");
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    idleSteps(2);

    $display("[TB] 0xA5 without parity");
    applyStimulus(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
    idleSteps(9);
    checkOutput("a5_frame", {22'd0, line_hist[9:0]}, {22'd0, 10'b0101001011});
    idleSteps(2);

    $display("[TB] 0xA5 with even and odd parity");
    applyStimulus(1'b1, 1'b1, 8'hA5, 1'b1, 1'b0);
    idleSteps(10);
    checkOutput("a5_even_par", {31'd0, line_hist[1]}, 32'd0);
    checkOutput("a5_even_stop", {31'd0, line_hist[0]}, 32'd1);
    idleSteps(1);
    applyStimulus(1'b1, 1'b1, 8'hA5, 1'b1, 1'b1);
    idleSteps(10);
    checkOutput("a5_odd_par", {31'd0, line_hist[1]}, 32'd1);
    checkOutput("a5_odd_stop", {31'd0, line_hist[0]}, 32'd1);
    idleSteps(1);

    $display("[TB] inputs changed mid-frame");
    applyStimulus(1'b1, 1'b1, 8'h01, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'h01, 1'b1, 1'b1);
    for (int i = 3; i <= 11; i++)
      applyStimulus(1'b1, (i <= 6), 8'hFF, 1'b0, 1'b0);
    checkOutput("hold_frame", {21'd0, line_hist[10:0]}, {21'd0, 11'b01000000001});
    idleSteps(2);

    $display("[TB] back-to-back frames");
    applyStimulus(1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);
    for (int i = 2; i <= 12; i++)
      applyStimulus(1'b1, 1'b1, (i < 5) ? 8'h3C : 8'hC3, 1'b0, 1'b0);
    for (int i = 13; i <= 21; i++)
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("b2b_frames", {11'd0, line_hist[20:0]}, {11'd0, 21'b000111100110110000111});
    idleSteps(2);

    $display("[TB] reset in DATA bit 4");
    applyStimulus(1'b1, 1'b1, 8'h96, 1'b1, 1'b0);
    idleSteps(5);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("abort_tx", {31'd0, tx_out}, 32'd1);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    applyStimulus(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
    idleSteps(9);
    checkOutput("after_abort", {22'd0, line_hist[9:0]}, {22'd0, 10'b0101010101});
    idleSteps(2);

    $display("[TB] reset with data_valid");
    applyStimulus(1'b0, 1'b1, 8'hAA, 1'b1, 1'b0);
    checkOutput("rst_prio_tx", {31'd0, tx_out}, 32'd1);
    idleSteps(3);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++)
      applyStimulus(($urandom_range(0, 59) != 0), ($urandom_range(0, 2) == 0),
                    8'($urandom), 1'($urandom), 1'($urandom));
    idleSteps(14);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
